// File: rtl/config_pkt_ctrl.sv
// Config packet front-end: decodes write/read/burst flits from the router into
// configurator strobes and returns read data as response flits. Optional macro: CFG_BURST_EN.
module config_pkt_ctrl #(
  parameter int CDW = 21,
  parameter int CAW = 15,
  parameter int OPW = 2,
  parameter int FW  = OPW + CAW + CDW,
  parameter int RW  = CAW + CDW,
  parameter int BLW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [FW-1:0]  in_flit,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RW-1:0]  out_flit,
  output logic           config_we,
  output logic [CAW-1:0] config_waddr,
  output logic [CDW-1:0] config_wdata,
  output logic           config_re,
  output logic [CAW-1:0] config_raddr,
  input  logic [CDW-1:0] config_rdata,
  output logic           busy,
  output logic [7:0]     err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_CAP, S_RESP, S_BURST
  } state_e;

  localparam logic [OPW-1:0] OP_NOP   = 2'b00;
  localparam logic [OPW-1:0] OP_WRITE = 2'b01;
  localparam logic [OPW-1:0] OP_READ  = 2'b10;
  localparam logic [OPW-1:0] OP_BURST = 2'b11;

  state_e         state_q, state_d;
  logic           we_q, we_d, re_q, re_d;
  logic [CAW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [CDW-1:0] wdata_q, wdata_d;
  logic           out_valid_q, out_valid_d;
  logic [RW-1:0]  out_flit_q, out_flit_d;
  logic [7:0]     err_q, err_d;
`ifdef CFG_BURST_EN
  logic [CAW-1:0] base_q, base_d;
  logic [BLW-1:0] cnt_q, cnt_d;
`endif

  logic [OPW-1:0] flit_op;
  logic [CAW-1:0] flit_addr;
  logic [CDW-1:0] flit_data;
  logic           accept;

  assign flit_op   = in_flit[FW-1 -: OPW];
  assign flit_addr = in_flit[CDW +: CAW];
  assign flit_data = in_flit[CDW-1:0];

  // in_ready is forced low while reset is asserted so no flit slips in on the reset edge.
  assign in_ready = ~rst & ((state_q == S_IDLE) | (state_q == S_BURST));
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    raddr_d     = raddr_q;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    err_d       = err_q;
`ifdef CFG_BURST_EN
    base_d      = base_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (flit_op)
            OP_NOP: ;
            OP_WRITE: begin
              state_d = S_WR;
              we_d    = 1'b1;
              waddr_d = flit_addr;
              wdata_d = flit_data;
            end
            OP_READ: begin
              state_d = S_RD;
              re_d    = 1'b1;
              raddr_d = flit_addr;
            end
            OP_BURST: begin
`ifdef CFG_BURST_EN
              if (flit_data[BLW-1:0] != '0) begin
                state_d = S_BURST;
                base_d  = flit_addr;
                cnt_d   = flit_data[BLW-1:0];
              end
`else
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
            end
            default: ;
          endcase
        end
      end
      S_WR:  state_d = S_IDLE;
      S_RD:  state_d = S_CAP;
      // Configurator returns data the cycle after the strobe; raddr_q is still held here.
      S_CAP: begin
        out_flit_d  = {raddr_q, config_rdata};
        out_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef CFG_BURST_EN
      S_BURST: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = base_q;
          wdata_d = flit_data;
          base_d  = base_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == BLW'(1)) state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      err_q       <= '0;
`ifdef CFG_BURST_EN
      base_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      re_q        <= re_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      err_q       <= err_d;
`ifdef CFG_BURST_EN
      base_q      <= base_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign config_we    = we_q;
  assign config_re    = re_q;
  assign config_waddr = waddr_q;
  assign config_wdata = wdata_q;
  assign config_raddr = raddr_q;
  assign out_valid    = out_valid_q;
  assign out_flit     = out_flit_q;
  assign busy         = (state_q != S_IDLE);
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_config_pkt_ctrl.sv
// Directed bench for config_pkt_ctrl; exercises the CFG_BURST_EN or default op-11 path
// according to the same macro.
module tb_config_pkt_ctrl;

  localparam int CDW = 21;
  localparam int CAW = 15;
  localparam int FW  = 38;
  localparam int RW  = 36;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [FW-1:0]  in_flit;
  logic           out_valid;
  logic           out_ready;
  logic [RW-1:0]  out_flit;
  logic           config_we;
  logic [CAW-1:0] config_waddr;
  logic [CDW-1:0] config_wdata;
  logic           config_re;
  logic [CAW-1:0] config_raddr;
  logic [CDW-1:0] config_rdata = '0;
  logic           busy;
  logic [7:0]     err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;
  logic [CDW-1:0] rd_value = '0;

  config_pkt_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .config_we(config_we), .config_waddr(config_waddr), .config_wdata(config_wdata),
    .config_re(config_re), .config_raddr(config_raddr), .config_rdata(config_rdata),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Configurator model: read data is valid only in the cycle after config_re.
  always @(posedge clk) config_rdata <= config_re ? rd_value : 21'h1F0F0F;

  always @(negedge clk) if (config_we && config_re) overlap++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] op, input logic [CAW-1:0] a,
                                       input logic [CDW-1:0] d);
    return {op, a, d};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready",  in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_we",        config_we, 0);
    check("rst_re",        config_re, 0);
    check("rst_busy",      busy, 0);
    check("rst_err",       err_cnt, 0);
    check("rst_out_flit",  out_flit, 0);
    rst = 1'b0; #1;
    check("post_rst_in_ready", in_ready, 1);

    // NOP: accepted, nothing happens
    in_valid = 1'b1; in_flit = mk(2'b00, 15'h0123, 21'h00055);
    tick();
    in_valid = 1'b0;
    check("nop_we", config_we, 0);
    check("nop_re", config_re, 0);
    check("nop_busy", busy, 0);

    // 1: WRITE
    in_valid = 1'b1; in_flit = mk(2'b01, 15'h0001, 21'h00ABC);
    tick();
    in_valid = 1'b0;
    check("wr_we",       config_we, 1);
    check("wr_waddr",    config_waddr, 15'h0001);
    check("wr_wdata",    config_wdata, 21'h00ABC);
    check("wr_in_ready", in_ready, 0);
    check("wr_busy",     busy, 1);
    tick();
    check("wr_we_drop",  config_we, 0);
    check("wr_idle",     busy, 0);

    // 2: READ with immediate out_ready
    rd_value = 21'h01234;
    in_valid = 1'b1; in_flit = mk(2'b10, 15'h2005, 21'h0);
    tick();
    in_valid = 1'b0;
    check("rd_re",    config_re, 1);
    check("rd_raddr", config_raddr, 15'h2005);
    check("rd_we",    config_we, 0);
    tick();
    check("rd_re_drop",   config_re, 0);
    check("rd_raddr_hold", config_raddr, 15'h2005);
    check("rd_no_valid_t2", out_valid, 0);
    tick();
    check("rd_out_valid", out_valid, 1);
    check("rd_out_flit",  out_flit, {15'h2005, 21'h01234});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rd_done_valid", out_valid, 0);
    check("rd_done_busy",  busy, 0);

    // 3: READ with back-pressure for 5 cycles
    rd_value = 21'h0ABCD;
    in_valid = 1'b1; in_flit = mk(2'b10, 15'h1111, 21'h0);
    tick(); in_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    out_valid, 1);
      check("bp_flit",     out_flit, {15'h1111, 21'h0ABCD});
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_idle",  busy, 0);
    check("bp_release_ready", in_ready, 1);

`ifdef CFG_BURST_EN
    // 4: BURST wrapping across the top of the address space
    in_valid = 1'b1; in_flit = mk(2'b11, 15'h7FFE, 21'd3);
    tick();
    check("bh_busy", busy, 1);
    check("bh_in_ready", in_ready, 1);
    check("bh_we", config_we, 0);
    in_valid = 1'b0;
    tick();
    check("b_stall_we", config_we, 0);
    begin
      logic [CAW-1:0] exp_a [3];
      logic [CDW-1:0] exp_d [3];
      exp_a[0] = 15'h7FFE; exp_a[1] = 15'h7FFF; exp_a[2] = 15'h0000;
      exp_d[0] = 21'h10001; exp_d[1] = 21'h10002; exp_d[2] = 21'h10003;
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1; in_flit = mk(2'b01, 15'h5555, exp_d[i]);
        tick();
        check("b_we",    config_we, 1);
        check("b_waddr", config_waddr, exp_a[i]);
        check("b_wdata", config_wdata, exp_d[i]);
      end
    end
    in_valid = 1'b0;
    check("b_end_busy", busy, 0);
    tick();
    check("b_end_we", config_we, 0);
    // zero-length header is consumed with no writes
    in_valid = 1'b1; in_flit = mk(2'b11, 15'h0100, 21'd0);
    tick(); in_valid = 1'b0;
    check("b0_busy", busy, 0);
    check("b0_we", config_we, 0);
    check("b_err", err_cnt, 0);
`else
    // 5: op 11 is illegal, counted and dropped, saturating at 255
    begin
      logic strobe_seen = 1'b0;
      in_valid = 1'b1; in_flit = mk(2'b11, 15'h7FFE, 21'd3);
      tick();
      check("ill_err1", err_cnt, 1);
      check("ill_we",   config_we, 0);
      check("ill_re",   config_re, 0);
      check("ill_busy", busy, 0);
      for (int i = 0; i < 255; i++) begin
        tick();
        if (config_we || config_re) strobe_seen = 1'b1;
      end
      check("ill_err255", err_cnt, 255);
      tick();
      in_valid = 1'b0;
      check("ill_sat", err_cnt, 255);
      check("ill_strobes", strobe_seen, 0);
    end
`endif

    // 6: reset while a response is held
    rd_value = 21'h15555;
    in_valid = 1'b1; in_flit = mk(2'b10, 15'h3333, 21'h0);
    tick(); in_valid = 1'b0;
    tick(); tick();
    check("r6_valid", out_valid, 1);
    rst = 1'b1; #1;
    check("r6_in_ready_rst", in_ready, 0);
    tick();
    check("r6_out_valid", out_valid, 0);
    check("r6_busy",      busy, 0);
    check("r6_err",       err_cnt, 0);
    check("r6_in_ready_held", in_ready, 0);
    rst = 1'b0; #1;
    check("r6_in_ready", in_ready, 1);

    tick();
    check("we_re_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
